// File: rtl/norm_lzc_pipe.sv
// ---------------------------------------------------------------------------
// norm_lzc_pipe
//   Three-stage normaliser. Takes an unsigned magnitude and returns it
//   left-justified, together with the shift applied (leading-zero count), the
//   bit index of the leading one and a zero flag. A sideband tag travels with
//   every sample.
//
//   Stage 1 : register input data/tag
//   Stage 2 : register leading-zero tree result (valid bit + count)
//   Stage 3 : barrel shift + exponent subtraction, register outputs
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_data, in_tag     magnitude (bit WIDTH-1 is the MSB) and sideband tag
//   out_valid/out_ready downstream handshake
//   out_mant            in_data << lzc, zero for a zero input
//   out_lzc, out_exp    leading-zero count and WIDTH-1-lzc, zero for zero input
//   out_zero            input was all zeros
//   out_tag             tag belonging to this sample
//
// Backpressure stalls the whole pipeline: when the output holds a valid
// sample that is not being taken, every stage (bubbles included) holds.
// ---------------------------------------------------------------------------
module norm_lzc_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int LZW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [LZW-1:0]   out_lzc,
    output logic [LZW-1:0]   out_exp,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [LZW-1:0] MAX_IDX = LZW'(WIDTH - 1);

    // Pipeline state
    logic             v1_reg, v2_reg, v3_reg;
    logic [WIDTH-1:0] d1_reg, d2_reg;
    logic [TAG_W-1:0] t1_reg, t2_reg;
    logic             nz2_reg;
    logic [LZW-1:0]   lzc2_reg;

    logic [WIDTH-1:0] mant_reg;
    logic [LZW-1:0]   lzc_reg;
    logic [LZW-1:0]   exp_reg;
    logic             zero_reg;
    logic [TAG_W-1:0] tag_reg;

    logic             stall;

    assign stall    = v3_reg && !out_ready;
    assign in_ready = !stall;

    // -----------------------------------------------------------------------
    // Leading-zero tree on stage-1 data, stored as a binary heap: node k has
    // children 2k and 2k+1, root is node 1, leaves are WIDTH..2*WIDTH-1.
    // Leaf WIDTH+i holds b[i], where b[0] is the MSB of the data.
    // A node's count is the left count if the left half has a one, otherwise
    // the right count plus the left half's width.
    // -----------------------------------------------------------------------
    logic [2*WIDTH-1:1]            v_h;
    logic [2*WIDTH-1:1][LZW-1:0]   p_h;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_leaf
            assign v_h[WIDTH+gi] = d1_reg[WIDTH-1-gi];
            assign p_h[WIDTH+gi] = '0;
        end
        for (genvar gl = 0; gl < LZW; gl++) begin : gen_lvl
            localparam logic [LZW-1:0] HALF = LZW'(WIDTH >> (gl + 1));
            for (genvar gn = 0; gn < (1 << gl); gn++) begin : gen_node
                localparam int K = (1 << gl) + gn;
                assign v_h[K] = v_h[2*K] | v_h[2*K+1];
                assign p_h[K] = v_h[2*K] ? p_h[2*K] : (p_h[2*K+1] | HALF);
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Logarithmic barrel shifter on stage-2 data, one stage per count bit.
    // -----------------------------------------------------------------------
    logic [LZW:0][WIDTH-1:0] sh;

    assign sh[0] = d2_reg;
    generate
        for (genvar gi = 0; gi < LZW; gi++) begin : gen_shift
            assign sh[gi+1] = lzc2_reg[gi] ? (sh[gi] << (1 << gi)) : sh[gi];
        end
    endgenerate

    logic [WIDTH-1:0] mant_next;
    logic [LZW-1:0]   lzc_next;
    logic [LZW-1:0]   exp_next;

    always_comb begin
        mant_next = '0;
        lzc_next  = '0;
        exp_next  = '0;
        if (nz2_reg) begin
            mant_next = sh[LZW];
            lzc_next  = lzc2_reg;
            exp_next  = MAX_IDX - lzc2_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Stage registers. Data registers only load behind a valid bit so that
    // bubbles never disturb the held output fields.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
            v3_reg   <= 1'b0;
            d1_reg   <= '0;
            t1_reg   <= '0;
            d2_reg   <= '0;
            t2_reg   <= '0;
            nz2_reg  <= 1'b0;
            lzc2_reg <= '0;
            mant_reg <= '0;
            lzc_reg  <= '0;
            exp_reg  <= '0;
            zero_reg <= 1'b0;
            tag_reg  <= '0;
        end else if (!stall) begin
            v1_reg <= in_valid;
            if (in_valid) begin
                d1_reg <= in_data;
                t1_reg <= in_tag;
            end

            v2_reg <= v1_reg;
            if (v1_reg) begin
                d2_reg   <= d1_reg;
                t2_reg   <= t1_reg;
                nz2_reg  <= v_h[1];
                lzc2_reg <= p_h[1];
            end

            v3_reg <= v2_reg;
            if (v2_reg) begin
                mant_reg <= mant_next;
                lzc_reg  <= lzc_next;
                exp_reg  <= exp_next;
                zero_reg <= !nz2_reg;
                tag_reg  <= t2_reg;
            end
        end
    end

    assign out_valid = v3_reg;
    assign out_mant  = mant_reg;
    assign out_lzc   = lzc_reg;
    assign out_exp   = exp_reg;
    assign out_zero  = zero_reg;
    assign out_tag   = tag_reg;

endmodule

// File: doc/norm_lzc_pipe.md
Name: norm_lzc_pipe

Overview:
- Pipelined normaliser that consumes leading-zero counts from the clz tree.
- Takes an unsigned WIDTH-bit magnitude and produces:
  - a left-justified mantissa (MSB set),
  - the shift amount,
  - the binary exponent of the leading one,
  - a zero flag.
- Sits between the integer datapath and the float-pack / divider-setup logic.
- Uses valid/ready handshakes on both sides, with full-pipeline stall on backpressure.

Parameters:
- WIDTH, 16, input/mantissa width; power of two, 4..64.
- TAG_W, 4, sideband tag width carried alongside each sample.
- LZW, `CLOG2(WIDTH), localparam; width of shift/exponent fields.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  WIDTH  unsigned magnitude; bit WIDTH-1 is the MSB, and the MSB maps to clz b[0].
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_mant  out  WIDTH  in_data << lzc; all-zero when out_zero=1.
- out_lzc  out  LZW  leading-zero count (0..WIDTH-1); 0 when out_zero=1.
- out_exp  out  LZW  WIDTH-1-lzc, i.e. the bit index of the leading one; 0 when out_zero=1.
- out_zero  out  1  input was all zeros.
- out_tag  out  TAG_W  tag of this sample.

Behaviour:
- Three register stages, each with its own valid bit v1/v2/v3; out_valid = v3.
  - S1: registers in_data, in_tag.
  - S2: registers the clz result (vout, pout) from a combinational clz instance on the S1 data, plus the data and tag.
  - S3: performs the barrel shift and exponent subtraction, then registers all outputs.
- Latency: exactly 3 cycles from the accepting edge (in_valid && in_ready) to out_valid, with no backpressure.
- Throughput: 1 sample per cycle.
- Handshake:
  - stall = v3 && !out_ready.
  - in_ready = !stall (combinational).
  - When stall=1, all stages, including bubbles, hold their contents.
  - When stall=0, every stage advances; a stage with no valid predecessor loads v=0.
  - Pipeline bubbles are not compressed while stalled.
  - A sample is transferred when out_valid && out_ready.
  - Outputs are stable while out_valid && !out_ready.
  - in_data is ignored when in_valid=0 or in_ready=0.
- Arithmetic:
  - lzc = clz pout.
  - zero = !vout.
  - mant = data << lzc, with zeros filled at the LSB.
  - exp = (WIDTH-1) - lzc, computed LZW bits wide; no overflow is possible.
  - On zero: force mant, lzc and exp to 0 and set out_zero=1.
- Reset:
  - All valid bits, out_mant, out_lzc, out_exp, out_zero and out_tag clear to 0.
  - in_ready=1 in the cycle after reset deasserts; while rst=1, in_ready follows stall and therefore reads 1.
  - Reset mid-stream discards every in-flight sample; no output is produced for them.
- Simultaneous events:
  - out_ready rising in the same cycle as a new in_valid means both the output transfer and the input accept occur.
  - rst has priority over all handshakes.

Test Plan (WIDTH=16, TAG_W=4):
- Single sample, in_data=0x0001, tag=3 -> 3 cycles later: out_mant=0x8000, out_lzc=15, out_exp=0, out_zero=0, out_tag=3.
- in_data=0x8000, then 0x00F0, then 0x0000 on back-to-back cycles with out_ready=1 -> outputs on consecutive cycles:
  - (0x8000, lzc 0, exp 15, zero 0)
  - (0xF000, lzc 8, exp 7, zero 0)
  - (0x0000, lzc 0, exp 0, zero 1)
- Stream of 8 samples 0x0001<<k (k=0..7) with out_ready low for cycles 5-8 -> in_ready low during the stall, no sample lost or duplicated, outputs in order with lzc = 15-k and outputs held stable while stalled.
- Assert rst for 1 cycle while 3 samples are in flight -> out_valid=0 and all outputs 0 next cycle; the following sample 0x0300 emerges 3 cycles after acceptance as mant 0xC000, lzc 6.
- Random 10k samples with random in_valid/out_ready -> scoreboard confirms:
  - mant[15]=1 for every nonzero sample,
  - mant>>lzc == data,
  - exp == 15-lzc,
  - tags in order.
